// File: rtl/fp_addsub_pipe_if.sv
// Valid/ready bundle for fp_addsub_pipe.
//   master : producer side, drives the operation (in_*) and accepts results (out_ready)
//   slave  : adder side, reports in_ready and drives the result (out_*)
//   in_*   : operands A/B, in_sub (1 = A-B), opaque tag
//   out_*  : result word, returned tag, flags {invalid, overflow, underflow}
interface fp_addsub_pipe_if #(
    parameter int I_EXP = 8,
    parameter int I_MNT = 23,
    parameter int TAG_W = 4
);
    localparam int I_DATA = I_EXP + I_MNT + 1;

    logic              in_valid;
    logic              in_ready;
    logic [I_DATA-1:0] in_a;
    logic [I_DATA-1:0] in_b;
    logic              in_sub;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [I_DATA-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic [2:0]        out_flags;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_flags
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Four-stage floating-point adder/subtractor with round-to-nearest-even.
//   clk   : clock
//   reset : synchronous, active-high; drops every in-flight operation
//   bus   : fp_addsub_pipe_if slave port (in_* operation, out_* result, flags)
// Stages: S1 unpack/classify/compare, S2 align + add/sub, S3 normalise,
// S4 round/pack into the output registers. The whole pipe stalls as one when
// a result is held and downstream is not ready.
module fp_addsub_pipe #(
    parameter int I_EXP = 8,
    parameter int I_MNT = 23,
    parameter int TAG_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    fp_addsub_pipe_if.slave bus
);
    localparam int I_DATA = I_EXP + I_MNT + 1;
    localparam int FW     = I_MNT + 4;      // {hidden, mnt, guard, round, sticky}
    localparam int EW     = I_EXP + 2;      // signed working exponent
    localparam logic [I_EXP-1:0]  EXP_ONES = '1;
    localparam logic [I_EXP-1:0]  SH_MAX   = I_EXP'(I_MNT + 3);
    localparam logic [I_DATA-1:0] QNAN     = {1'b0, EXP_ONES, 1'b1, {(I_MNT-1){1'b0}}};

    // Pipeline registers
    logic                    v1_q, v2_q, v3_q;
    logic [TAG_W-1:0]        tag1_q, tag2_q, tag3_q;
    logic                    spec1_q, spec2_q, spec3_q;
    logic                    inv1_q, inv2_q, inv3_q;
    logic [I_DATA-1:0]       res1_q, res2_q, res3_q;
    logic                    sgn1_q, sgn2_q, sgn3_q;
    logic                    sub1_q;
    logic [I_EXP-1:0]        e1_q, e2_q, diff1_q;
    logic [I_MNT-1:0]        lgm1_q, smm1_q;
    logic [FW:0]             sum2_q;
    logic                    zero3_q;
    logic signed [EW-1:0]    nexp3_q;
    logic [FW-1:0]           nrm3_q;
    logic                    out_valid_q;
    logic [I_DATA-1:0]       out_data_q;
    logic [TAG_W-1:0]        out_tag_q;
    logic [2:0]              out_flags_q;

    logic advance;
    assign advance = !out_valid_q || bus.out_ready;

    // ---------------- S1: unpack, classify, compare ----------------
    logic             a_s, b_s;
    logic [I_EXP-1:0] a_e, b_e;
    logic [I_MNT-1:0] a_m, b_m;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge;

    assign {a_s, a_e, a_m} = bus.in_a;
    assign b_s             = bus.in_b[I_DATA-1] ^ bus.in_sub;
    assign {b_e, b_m}      = bus.in_b[I_DATA-2:0];
    assign a_zero = (a_e == '0);
    assign b_zero = (b_e == '0);
    assign a_inf  = (a_e == EXP_ONES) && (a_m == '0);
    assign b_inf  = (b_e == EXP_ONES) && (b_m == '0);
    assign a_nan  = (a_e == EXP_ONES) && (a_m != '0);
    assign b_nan  = (b_e == EXP_ONES) && (b_m != '0);
    assign a_ge   = {a_e, a_m} >= {b_e, b_m};

    logic             spec1_d, inv1_d, sgn1_d;
    logic [I_DATA-1:0] res1_d;
    logic [I_EXP-1:0]  e1_d, diff1_d;
    logic [I_MNT-1:0]  lgm1_d, smm1_d;

    // Zero/Inf/NaN outcomes are settled here and carried to the output
    // untouched, so the arithmetic path only ever sees two normal operands.
    always_comb begin
        spec1_d = 1'b1;
        inv1_d  = 1'b0;
        res1_d  = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
            res1_d = QNAN;
            inv1_d = 1'b1;
        end else if (a_inf) begin
            res1_d = {a_s, EXP_ONES, {I_MNT{1'b0}}};
        end else if (b_inf) begin
            res1_d = {b_s, EXP_ONES, {I_MNT{1'b0}}};
        end else if (a_zero && b_zero) begin
            res1_d = {a_s & b_s, {(I_DATA-1){1'b0}}};
        end else if (a_zero) begin
            res1_d = {b_s, b_e, b_m};
        end else if (b_zero) begin
            res1_d = bus.in_a;
        end else begin
            spec1_d = 1'b0;
        end
        sgn1_d  = a_ge ? a_s : b_s;
        e1_d    = a_ge ? a_e : b_e;
        lgm1_d  = a_ge ? a_m : b_m;
        smm1_d  = a_ge ? b_m : a_m;
        diff1_d = a_ge ? (a_e - b_e) : (b_e - a_e);
    end

    // ---------------- S2: align and add/subtract ----------------
    logic [FW-1:0]   sm_f, lg_f, aln;
    logic [2*FW-2:0] sm_ext;
    logic [FW:0]     sum2_d;

    always_comb begin
        sm_f   = {1'b1, smm1_q, 3'b000};
        lg_f   = {1'b1, lgm1_q, 3'b000};
        sm_ext = {sm_f, {(FW-1){1'b0}}} >> diff1_q;
        if (diff1_q >= SH_MAX) begin
            aln = FW'(1);
        end else begin
            // Everything shifted past the sticky position collapses into it.
            aln = {sm_ext[2*FW-2:FW], sm_ext[FW-1] | (|sm_ext[FW-2:0])};
        end
        sum2_d = sub1_q ? ({1'b0, lg_f} - {1'b0, aln}) : ({1'b0, lg_f} + {1'b0, aln});
    end

    // ---------------- S3: normalise ----------------
    logic [EW-1:0]        lz;
    logic                 lz_found;
    logic [FW-1:0]        nrm3_d;
    logic signed [EW-1:0] nexp3_d;

    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int unsigned i = 0; i < FW; i++) begin
            if (!lz_found && sum2_q[FW-1-i]) begin
                lz       = EW'(i);
                lz_found = 1'b1;
            end
        end
        if (sum2_q[FW]) begin
            nrm3_d  = {sum2_q[FW:2], sum2_q[1] | sum2_q[0]};
            nexp3_d = $signed({2'b00, e2_q}) + $signed(EW'(1));
        end else begin
            nrm3_d  = sum2_q[FW-1:0] << lz;
            nexp3_d = $signed({2'b00, e2_q}) - $signed(lz);
        end
    end

    // ---------------- S4: round and pack ----------------
    logic                 rnd_up;
    logic [I_MNT+1:0]     rnd;
    logic signed [EW-1:0] rexp;
    logic [I_MNT-1:0]     mnt;
    logic [I_DATA-1:0]    data_d;
    logic [2:0]           flags_d;

    always_comb begin
        rnd_up  = nrm3_q[2] & (nrm3_q[1] | nrm3_q[0] | nrm3_q[3]);
        rnd     = {1'b0, nrm3_q[FW-1:3]} + {{(I_MNT+1){1'b0}}, rnd_up};
        rexp    = nexp3_q + $signed({{(EW-1){1'b0}}, rnd[I_MNT+1]});
        mnt     = rnd[I_MNT+1] ? rnd[I_MNT:1] : rnd[I_MNT-1:0];
        data_d  = '0;
        flags_d = '0;
        if (spec3_q) begin
            data_d  = res3_q;
            flags_d = {inv3_q, 2'b00};
        end else if (zero3_q) begin
            data_d = '0;
        end else if (nexp3_q[EW-1] || (nexp3_q == '0)) begin
            data_d  = {sgn3_q, {(I_DATA-1){1'b0}}};
            flags_d = 3'b001;
        end else if (rexp >= $signed({2'b00, EXP_ONES})) begin
            data_d  = {sgn3_q, EXP_ONES, {I_MNT{1'b0}}};
            flags_d = 3'b010;
        end else begin
            data_d = {sgn3_q, rexp[I_EXP-1:0], mnt};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_flags_q <= '0;
        end else if (advance) begin
            v1_q    <= bus.in_valid;
            tag1_q  <= bus.in_tag;
            spec1_q <= spec1_d;
            inv1_q  <= inv1_d;
            res1_q  <= res1_d;
            sgn1_q  <= sgn1_d;
            sub1_q  <= a_s ^ b_s;
            e1_q    <= e1_d;
            diff1_q <= diff1_d;
            lgm1_q  <= lgm1_d;
            smm1_q  <= smm1_d;

            v2_q    <= v1_q;
            tag2_q  <= tag1_q;
            spec2_q <= spec1_q;
            inv2_q  <= inv1_q;
            res2_q  <= res1_q;
            sgn2_q  <= sgn1_q;
            e2_q    <= e1_q;
            sum2_q  <= sum2_d;

            v3_q    <= v2_q;
            tag3_q  <= tag2_q;
            spec3_q <= spec2_q;
            inv3_q  <= inv2_q;
            res3_q  <= res2_q;
            sgn3_q  <= sgn2_q;
            zero3_q <= (sum2_q == '0);
            nexp3_q <= nexp3_d;
            nrm3_q  <= nrm3_d;

            out_valid_q <= v3_q;
            out_data_q  <= data_d;
            out_tag_q   <= tag3_q;
            out_flags_q <= flags_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_flags = out_flags_q;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe (single precision: I_EXP=8, I_MNT=23).
// Directed vector table, randomized streaming against an exact-arithmetic
// reference model, back-pressure and mid-flight reset sequences.
module tb_fp_addsub_pipe;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp_addsub_pipe_if #(.I_EXP(8), .I_MNT(23), .TAG_W(4)) bus ();

    fp_addsub_pipe #(.I_EXP(8), .I_MNT(23), .TAG_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Exact reference: operands become integers on a common exponent grid,
    // are summed exactly, then rounded to nearest-even. Returns {data, flags}.
    function automatic logic [34:0] ref_fp(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic sa, sb, sgn;
        int ea, eb, emin, p, ex, sh;
        logic [299:0] va, vb, mag, q, rem, half;
        logic nan_a, nan_b, inf_a, inf_b;
        sa = a[31]; sb = b[31] ^ sub;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        nan_a = (ea == 255) && (a[22:0] != 0);
        nan_b = (eb == 255) && (b[22:0] != 0);
        inf_a = (ea == 255) && (a[22:0] == 0);
        inf_b = (eb == 255) && (b[22:0] == 0);
        if (nan_a || nan_b || (inf_a && inf_b && sa != sb)) return {32'h7FC00000, 3'b100};
        if (inf_a) return {sa, 8'hFF, 23'd0, 3'b000};
        if (inf_b) return {sb, 8'hFF, 23'd0, 3'b000};
        if (ea == 0 && eb == 0) return {sa & sb, 31'd0, 3'b000};
        if (ea == 0) return {sb, b[30:0], 3'b000};
        if (eb == 0) return {a, 3'b000};
        emin = (ea < eb) ? ea : eb;
        va = 300'({1'b1, a[22:0]}) << (ea - emin);
        vb = 300'({1'b1, b[22:0]}) << (eb - emin);
        if (sa == sb) begin
            mag = va + vb; sgn = sa;
        end else if (va >= vb) begin
            mag = va - vb; sgn = sa;
        end else begin
            mag = vb - va; sgn = sb;
        end
        if (mag == 0) return 35'd0;
        p = -1;
        for (int i = 299; i >= 0; i--) if (p < 0 && mag[i]) p = i;
        ex = emin + p - 23;
        if (ex <= 0) return {sgn, 31'd0, 3'b001};
        if (p > 23) begin
            sh   = p - 23;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 300'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q[24]) begin q = q >> 1; ex++; end
        end else begin
            q = mag << (23 - p);
        end
        if (ex >= 255) return {sgn, 8'hFF, 23'd0, 3'b010};
        return {sgn, 8'(ex), q[22:0], 3'b000};
    endfunction

    function automatic logic [31:0] rnd_fp(input logic [7:0] near);
        logic [7:0]  e;
        logic [22:0] m;
        int r;
        r = $urandom_range(0, 19);
        if (r == 0)      e = 8'h00;
        else if (r == 1) e = 8'hFF;
        else if (r < 12) e = near ^ 8'($urandom_range(0, 3));
        else if (r < 14) e = 8'hFE;
        else             e = 8'($urandom_range(1, 254));
        r = $urandom_range(0, 7);
        if (r == 0)      m = '0;
        else if (r == 1) m = '1;
        else             m = 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    // Scoreboard / monitor, sampled on the falling edge
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  t;
        logic [2:0]  f;
    } exp_t;
    exp_t        expq[$];
    exp_t        e_pop;
    logic [34:0] r_mon;
    int          n_out = 0;
    bit          saw_stall = 0;
    logic        prev_stall = 0;
    logic [38:0] prev_out;

    always @(negedge clk) begin
        if (reset) begin
            expq.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall)
                check("hold_stable", {bus.out_valid, bus.out_data, bus.out_tag, bus.out_flags}, {1'b1, prev_out});
            if (bus.in_valid && bus.in_ready) begin
                r_mon = ref_fp(bus.in_a, bus.in_b, bus.in_sub);
                expq.push_back({r_mon[34:3], bus.in_tag, r_mon[2:0]});
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (expq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got data %h tag %h, expected no output", bus.out_data, bus.out_tag);
                end else begin
                    e_pop = expq.pop_front();
                    check("sb_data",  bus.out_data,  e_pop.d);
                    check("sb_tag",   bus.out_tag,   e_pop.t);
                    check("sb_flags", bus.out_flags, e_pop.f);
                end
            end
            if (!bus.in_ready) saw_stall = 1;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_data, bus.out_tag, bus.out_flags};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [3:0] tag, output int lat);
        bus.in_a = a; bus.in_b = b; bus.in_sub = sub; bus.in_tag = tag;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [2:0]  flags;
    } vec_t;
    vec_t vecs [14];

    initial begin
        int lat;
        int k;
        bit acc;
        bit saw;
        int i;
        int n_out0;
        logic [31:0] oa [8];
        logic [31:0] ob [8];

        vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
        vecs[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000};
        vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000};
        vecs[4]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000};
        vecs[5]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b000};
        vecs[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010};
        vecs[7]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100};
        vecs[8]  = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001};
        vecs[9]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100};
        vecs[10] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000};
        vecs[11] = '{32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000};
        vecs[12] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000};
        vecs[13] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000};

        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sub = 1'b0; bus.in_tag = '0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        #1;
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data,  0);
        check("rst_out_tag",   bus.out_tag,   0);
        check("rst_out_flags", bus.out_flags, 0);

        // Directed table
        for (int v = 0; v < 14; v++) begin
            do_op(vecs[v].a, vecs[v].b, vecs[v].sub, (v == 0) ? 4'd3 : 4'(v), lat);
            check("vec_latency", lat, 4);
            check("vec_data",    bus.out_data,  vecs[v].res);
            check("vec_tag",     bus.out_tag,   (v == 0) ? 4'd3 : 4'(v));
            check("vec_flags",   bus.out_flags, vecs[v].flags);
            step();
        end

        // Randomized streaming with random back-pressure
        for (int c = 0; c < 400; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
                bus.in_a     = rnd_fp(8'($urandom_range(0, 255)));
                bus.in_b     = rnd_fp(bus.in_a[30:23]);
                bus.in_sub   = 1'($urandom);
                bus.in_tag   = 4'($urandom);
                bus.in_valid = 1'b1;
            end
            #1;
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) bus.in_valid = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        k = 0;
        while (expq.size() != 0 && k < 50) begin step(); k++; end
        check("rand_drain", expq.size(), 0);

        // Back-pressure: 8 back-to-back ops, out_ready low in cycles 5..8
        for (int j = 0; j < 8; j++) begin
            oa[j] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
            ob[j] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
        end
        step();
        n_out0 = n_out;
        saw_stall = 0;
        i = 0;
        for (int c = 1; c <= 24; c++) begin
            bus.out_ready = !(c >= 5 && c <= 8);
            if (i < 8) begin
                bus.in_a = oa[i]; bus.in_b = ob[i]; bus.in_sub = 1'(i); bus.in_tag = 4'(i);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_in_ready_dropped", saw_stall, 1);
        check("bp_out_count", n_out - n_out0, 8);
        check("bp_queue_empty", expq.size(), 0);

        // Reset with three operations in flight
        for (int j = 0; j < 3; j++) begin
            bus.in_a = 32'h3F800000; bus.in_b = 32'h40000000; bus.in_sub = 1'b0; bus.in_tag = 4'(9 + j);
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_out_valid", bus.out_valid, 0);
        check("rst_mid_in_ready",  bus.in_ready,  1);
        saw = 0;
        repeat (8) begin
            if (bus.out_valid) saw = 1;
            step();
        end
        check("rst_mid_no_emit", saw, 0);
        do_op(32'h40400000, 32'h3F800000, 1'b1, 4'd7, lat);
        check("post_rst_latency", lat, 4);
        check("post_rst_data",    bus.out_data, 32'h40000000);
        check("post_rst_tag",     bus.out_tag,  4'd7);
        step();
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
